// File: rtl/ofmap_port_arbiter.sv
// ofmap_port_arbiter
//   Shares the single-port ofmap SRAM between two requesters:
//     A : compute-side writeback / read-modify-write (memory controller)
//     B : host / readout DMA
//   A has fixed priority. B is forced through after STARVE_LIMIT consecutive
//   denied cycles. In-flight reads carry an owner tag down a RD_LATENCY-deep
//   pipeline, so each read response is raised only toward the port that issued it.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata A request (held until a_gnt)
//   a_gnt                     A accepted this cycle (combinational)
//   a_rvalid/a_rdata          A read response, RD_LATENCY cycles after the grant
//   b_*                       same set for B
//   ram_we/ram_addr/ram_wdata SRAM command from the granted port
//   ram_rdata                 SRAM read data
//   starve_evt                1-cycle pulse after a forced B grant that displaced A
module ofmap_port_arbiter #(
  parameter int DATA_W       = 512,
  parameter int ADDR_W       = 10,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              starve_evt
);

  logic [7:0]        starve_cnt;
  logic              force_b;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_push;
  logic              rd_owner;

  // Tag pipeline: index 1 is the youngest entry, RD_LATENCY the output stage.
  logic [RD_LATENCY:1] vld_pipe;
  logic [RD_LATENCY:1] own_pipe;

  assign force_b = b_req & (starve_cnt == 8'(STARVE_LIMIT));

  // Grants are suppressed while reset is held so nothing reaches the SRAM.
  always_comb begin
    b_gnt = 1'b0;
    a_gnt = 1'b0;
    if (!rst) begin
      b_gnt = b_req & (~a_req | force_b);
      a_gnt = a_req & ~(b_req & (~a_req | force_b));
    end
  end

  // With no grant the address/data buses keep their last granted value so the
  // wide SRAM inputs do not toggle on idle cycles.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (a_gnt) begin
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end else if (b_gnt) begin
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (a_gnt | b_gnt) begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  // Counts consecutive cycles in which B waited behind A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      starve_evt <= 1'b0;
    end else begin
      starve_evt <= force_b & a_req;
      if (!b_req || b_gnt)
        starve_cnt <= '0;
      else if (a_gnt && starve_cnt != 8'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign rd_push  = (a_gnt & ~a_we) | (b_gnt & ~b_we);
  assign rd_owner = b_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_push;
      own_pipe[1] <= rd_owner;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
    end
  end

  assign a_rvalid = vld_pipe[RD_LATENCY] & ~own_pipe[RD_LATENCY];
  assign b_rvalid = vld_pipe[RD_LATENCY] &  own_pipe[RD_LATENCY];

  // Data is shared; consumers qualify with their own rvalid.
  assign a_rdata = ram_rdata;
  assign b_rdata = ram_rdata;

endmodule

// File: tb/tb_ofmap_port_arbiter.sv
// Bench for ofmap_port_arbiter: one instance at RD_LATENCY=1, one at 3, each
// attached to a behavioural SRAM. Expected read responses are queued when the
// read is issued and popped by a monitor when rvalid appears.
module tb_ofmap_port_arbiter;
  localparam int DW  = 512;
  localparam int AW  = 10;
  localparam int LIM = 8;

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---- instance 1: RD_LATENCY = 1 ----
  logic          rst, a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, starve_evt;
  logic [DW-1:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  ofmap_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1), .STARVE_LIMIT(LIM)) u_dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .starve_evt(starve_evt)
  );

  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] rp1;
  always @(posedge clk) begin
    if (ram_we) mem1[ram_addr] <= ram_wdata;
    rp1 <= mem1[ram_addr];
  end
  assign ram_rdata = rp1;

  // ---- instance 3: RD_LATENCY = 3 ----
  logic          rst3, a_req3, a_we3, b_req3, b_we3;
  logic [AW-1:0] a_addr3, b_addr3;
  logic [DW-1:0] a_wdata3, b_wdata3;
  logic          a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, ram_we3, starve_evt3;
  logic [DW-1:0] a_rdata3, b_rdata3, ram_wdata3, ram_rdata3;
  logic [AW-1:0] ram_addr3;

  ofmap_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(3), .STARVE_LIMIT(LIM)) u_dut3 (
    .clk(clk), .rst(rst3),
    .a_req(a_req3), .a_we(a_we3), .a_addr(a_addr3), .a_wdata(a_wdata3),
    .a_gnt(a_gnt3), .a_rvalid(a_rvalid3), .a_rdata(a_rdata3),
    .b_req(b_req3), .b_we(b_we3), .b_addr(b_addr3), .b_wdata(b_wdata3),
    .b_gnt(b_gnt3), .b_rvalid(b_rvalid3), .b_rdata(b_rdata3),
    .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .starve_evt(starve_evt3)
  );

  logic [DW-1:0] mem3 [1024];
  logic [DW-1:0] rp3 [3];
  always @(posedge clk) begin
    if (ram_we3) mem3[ram_addr3] <= ram_wdata3;
    rp3[0] <= mem3[ram_addr3];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign ram_rdata3 = rp3[2];

  // ---- scoreboard ----
  exp_t          q1[$];
  exp_t          q3[$];
  logic [DW-1:0] ref1 [int];

  task automatic chk1(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (a_rvalid || b_rvalid) begin
      if (q1.size() == 0) begin
        vecs++; errs++;
        $display("FAIL rsp1_unexpected: a_rvalid=%0b b_rvalid=%0b required none (cycle %0d)",
                 a_rvalid, b_rvalid, cyc);
      end else begin
        e = q1.pop_front();
        chk1("rsp1_onehot", a_rvalid & b_rvalid, 1'b0);
        chk1("rsp1_owner", b_rvalid, e.owner);
        chkd("rsp1_data", b_rvalid ? b_rdata : a_rdata, e.data);
        chki("rsp1_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (a_rvalid3 || b_rvalid3) begin
      if (q3.size() == 0) begin
        vecs++; errs++;
        $display("FAIL rsp3_unexpected: a_rvalid=%0b b_rvalid=%0b required none (cycle %0d)",
                 a_rvalid3, b_rvalid3, cyc);
      end else begin
        e = q3.pop_front();
        chk1("rsp3_owner", b_rvalid3, e.owner);
        chkd("rsp3_data", b_rvalid3 ? b_rdata3 : a_rdata3, e.data);
        chki("rsp3_cycle", cyc, e.due);
      end
    end
  end

  // ---- stimulus helpers ----
  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One uncontended access on instance 1, checked and scored, then next cycle.
  task automatic op(input bit port, input bit we, input int addr, input logic [DW-1:0] d);
    exp_t e;
    a_req = !port; a_we = we; a_addr = AW'(addr); a_wdata = d;
    b_req =  port; b_we = we; b_addr = AW'(addr); b_wdata = d;
    @(negedge clk);
    chk1(port ? "op_b_gnt" : "op_a_gnt", port ? b_gnt : a_gnt, 1'b1);
    chk1("op_ram_we", ram_we, we);
    chki("op_ram_addr", int'(ram_addr), addr);
    if (we) ref1[addr] = d;
    else begin
      e.owner = port; e.data = ref1[addr]; e.due = cyc + 1;
      q1.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n);
    a_req = 1'b0; b_req = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    rst3 = 1'b1; a_req3 = 0; a_we3 = 0; a_addr3 = '0; a_wdata3 = '0;
    b_req3 = 0; b_we3 = 0; b_addr3 = '0; b_wdata3 = '0;
    step(); step();

    // Reset holds off both requesters.
    a_req = 1; a_we = 1; a_addr = 10'h05; a_wdata = pat(8'hA5);
    b_req = 1; b_we = 0; b_addr = 10'h20;
    @(negedge clk);
    chk1("rst_a_gnt", a_gnt, 1'b0);
    chk1("rst_b_gnt", b_gnt, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_b_rvalid", b_rvalid, 1'b0);
    chk1("rst_starve_evt", starve_evt, 1'b0);
    step();

    // Release: A wins in the same cycle.
    rst = 1'b0;
    @(negedge clk);
    chk1("rel_a_gnt", a_gnt, 1'b1);
    chk1("rel_b_gnt", b_gnt, 1'b0);
    chk1("rel_ram_we", ram_we, 1'b1);
    chki("rel_ram_addr", int'(ram_addr), 5);
    ref1[5] = pat(8'hA5);
    step();

    // A reads back 0x05.
    b_req = 0; a_we = 0;
    @(negedge clk);
    chk1("rd_a_gnt", a_gnt, 1'b1);
    chk1("rd_ram_we", ram_we, 1'b0);
    e.owner = 1'b0; e.data = ref1[5]; e.due = cyc + 1;
    q1.push_back(e);
    step();

    // Idle: buses hold the last granted address.
    a_req = 0;
    @(negedge clk);
    chk1("idle_ram_we", ram_we, 1'b0);
    chki("idle_ram_addr", int'(ram_addr), 5);
    chk1("idle_a_gnt", a_gnt, 1'b0);
    step();

    // Fill, then interleaved A/B/A reads.
    op(0, 1, 'h10, pat(8'h11));
    op(1, 1, 'h20, pat(8'h22));
    op(0, 1, 'h30, pat(8'h33));
    op(0, 0, 'h10, '0);
    op(1, 0, 'h20, '0);
    op(0, 0, 'h30, '0);
    idle(3);

    // Starvation: A held continuously, B read pending from cycle 0.
    a_req = 1; a_we = 1; a_addr = 10'h50; a_wdata = pat(8'h55);
    b_req = 1; b_we = 0; b_addr = 10'h20;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) b_req = 0;
      @(negedge clk);
      chk1($sformatf("starve_a_gnt_%0d", k), a_gnt, k != 8);
      chk1($sformatf("starve_b_gnt_%0d", k), b_gnt, k == 8);
      chk1($sformatf("starve_evt_%0d", k), starve_evt, k == 9);
      if (k == 8) begin
        e.owner = 1'b1; e.data = ref1['h20]; e.due = cyc + 1;
        q1.push_back(e);
      end else ref1['h50] = pat(8'h55);
      step();
    end
    a_req = 0;
    @(negedge clk);
    chk1("starve_evt_after", starve_evt, 1'b0);
    idle(2);

    // Counter clears when B withdraws after 5 denied cycles.
    a_req = 1; a_we = 1; a_addr = 10'h51; a_wdata = pat(8'h66);
    b_req = 1; b_we = 0; b_addr = 10'h30;
    for (int k = 0; k < 15; k++) begin
      b_req = (k != 5);
      @(negedge clk);
      chk1($sformatf("cclr_b_gnt_%0d", k), b_gnt, k == 14);
      chk1($sformatf("cclr_a_gnt_%0d", k), a_gnt, k != 14);
      if (k == 14) begin
        e.owner = 1'b1; e.data = ref1['h30]; e.due = cyc + 1;
        q1.push_back(e);
      end else ref1['h51] = pat(8'h66);
      step();
    end

    // B alone is granted back to back.
    op(1, 1, 'h60, pat(8'h77));
    op(1, 1, 'h61, pat(8'h78));
    op(1, 0, 'h60, '0);
    idle(4);
    chki("q1_drained", q1.size(), 0);

    // ---- RD_LATENCY = 3 ----
    rst3 = 1'b0;
    step();
    b_req3 = 1; b_we3 = 1; b_addr3 = 10'h07; b_wdata3 = pat(8'h7E);
    @(negedge clk);
    chk1("l3_wr_b_gnt", b_gnt3, 1'b1);
    step();
    b_we3 = 0;
    @(negedge clk);
    chk1("l3_rd_b_gnt", b_gnt3, 1'b1);
    e.owner = 1'b1; e.data = pat(8'h7E); e.due = cyc + 3;
    q3.push_back(e);
    step();
    b_req3 = 0;
    repeat (5) step();
    chki("q3_drained", q3.size(), 0);

    // Read in flight when reset hits: it must never come back.
    b_req3 = 1;
    @(negedge clk);
    chk1("l3_rd2_b_gnt", b_gnt3, 1'b1);
    step();
    b_req3 = 0; rst3 = 1'b1;
    @(negedge clk);
    chk1("l3_rst_b_rvalid", b_rvalid3, 1'b0);
    step();
    rst3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1($sformatf("l3_flush_b_rvalid_%0d", k), b_rvalid3, 1'b0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1);
  end
endmodule
